assoc_wb_cache: RTL and testbench

// - N-way set-associative, write-back, write-allocate data/instruction cache with multi-word lines.
// - Sits between the MIPS core memory stage and the main memory model.
// - Core side: single-word req/ready; memory side: full-line req/ack handshake.
// - Successor of the direct-mapped single-word cache: adds ways, LRU replacement, line bursts and real miss stalls.

---
 rtl/cache_pkg.sv | 22 ++
 rtl/cache_lru.sv | 45 ++++
 rtl/assoc_wb_cache.sv | 178 +++++++++++++++++
 tb/tb_assoc_wb_cache.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared FSM state type and geometry helpers for the set-associative cache
package cache_pkg;

    typedef enum logic [1:0] {IDLE, WB, REFILL} state_e;

    function automatic int tag_width(input int addr_w, input int set_bits, input int word_bits);
        return addr_w - set_bits - word_bits - 2;
    endfunction

    function automatic int line_width(input int word_bits);
        return 32 << word_bits;
    endfunction

    function automatic int index_lsb(input int word_bits);
        return word_bits + 2;
    endfunction

    function automatic int way_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_lru.sv
// rtl/cache_lru.sv - per-set age-based LRU tracker; reports the oldest way of the addressed set
module cache_lru import cache_pkg::*; #(
    parameter int WAYS     = 2,
    parameter int SET_BITS = 6,
    localparam int WAY_W   = way_width(WAYS)
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                access_i,
    input  logic [SET_BITS-1:0] set_i,
    input  logic [WAY_W-1:0]    way_i,
    output logic [WAY_W-1:0]    victim_o
);
    localparam int SETS = 1 << SET_BITS;

    if (WAYS == 1) begin : g_direct
        assign victim_o = '0;
    end else begin : g_ages
        logic [WAY_W-1:0] age_q [WAYS][SETS];

        // Ages start as a permutation with way 0 oldest, so the update rule keeps them one.
        always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b) begin
                for (int s = 0; s < SETS; s++)
                    for (int w = 0; w < WAYS; w++)
                        age_q[w][s] <= WAY_W'(WAYS - 1 - w);
            end else if (access_i) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == way_i)
                        age_q[w][set_i] <= '0;
                    else if (age_q[w][set_i] < age_q[way_i][set_i])
                        age_q[w][set_i] <= age_q[w][set_i] + 1'b1;
                end
            end
        end

        always_comb begin
            victim_o = '0;
            for (int w = 0; w < WAYS; w++)
                if (age_q[w][set_i] == WAY_W'(WAYS - 1))
                    victim_o = WAY_W'(w);
        end
    end

endmodule

// File: rtl/assoc_wb_cache.sv
// rtl/assoc_wb_cache.sv - N-way write-back, write-allocate cache with full-line memory bursts
module assoc_wb_cache import cache_pkg::*; #(
    parameter int WAYS      = 2,
    parameter int SET_BITS  = 6,
    parameter int WORD_BITS = 2,
    parameter int ADDR_W    = 32,
    localparam int LINE_W   = line_width(WORD_BITS)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    localparam int TAG_W   = tag_width(ADDR_W, SET_BITS, WORD_BITS);
    localparam int WAY_W   = way_width(WAYS);
    localparam int SETS    = 1 << SET_BITS;
    localparam int IDX_LSB = index_lsb(WORD_BITS);
    localparam int LAT_W   = ADDR_W - IDX_LSB;

    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic              valid_q [WAYS][SETS];
    logic              dirty_q [WAYS][SETS];
    logic [LINE_W-1:0] data_q  [WAYS][SETS];

    state_e            state_q, state_d;
    logic [WAY_W-1:0]  vic_q, vic_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [TAG_W-1:0]     cpu_tag, lat_tag;
    logic [SET_BITS-1:0]  idx, lat_idx;
    logic [WORD_BITS-1:0] word;
    logic                 hit, lru_access, wr_hit, refill_done;
    logic [WAY_W-1:0]     hit_way, victim, lru_victim;
    logic                 unused_byte_lsbs;

    assign cpu_tag          = cpu_addr[ADDR_W-1 -: TAG_W];
    assign idx              = cpu_addr[IDX_LSB +: SET_BITS];
    assign word             = cpu_addr[2 +: WORD_BITS];
    assign unused_byte_lsbs = ^cpu_addr[1:0];
    assign lat_idx          = lat_q[SET_BITS-1:0];
    assign lat_tag          = lat_q[LAT_W-1 -: TAG_W];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (valid_q[w][idx] && tag_q[w][idx] == cpu_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
    end

    // Lowest-index invalid way wins; only a full set falls back to the LRU choice.
    always_comb begin
        victim = lru_victim;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid_q[w][idx])
                victim = WAY_W'(w);
    end

    cache_lru #(.WAYS(WAYS), .SET_BITS(SET_BITS)) u_lru (
        .clk      (clk),
        .rst_b    (rst_b),
        .access_i (lru_access),
        .set_i    (idx),
        .way_i    (hit_way),
        .victim_o (lru_victim)
    );

    assign cpu_rdata = (state_q == IDLE && hit) ? data_q[hit_way][idx][{word, 5'd0} +: 32] : '0;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    always_comb begin
        state_d     = state_q;
        vic_d       = vic_q;
        lat_d       = lat_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_ready   = 1'b0;
        lru_access  = 1'b0;
        wr_hit      = 1'b0;
        refill_done = 1'b0;
        case (state_q)
            IDLE: if (cpu_req) begin
                if (hit) begin
                    cpu_ready  = 1'b1;
                    lru_access = 1'b1;
                    wr_hit     = cpu_we;
                end else begin
                    vic_d     = victim;
                    lat_d     = cpu_addr[ADDR_W-1:IDX_LSB];
                    mem_req_d = 1'b1;
                    if (valid_q[victim][idx] && dirty_q[victim][idx]) begin
                        state_d     = WB;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {tag_q[victim][idx], idx, {IDX_LSB{1'b0}}};
                        mem_wdata_d = data_q[victim][idx];
                    end else begin
                        state_d    = REFILL;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {cpu_addr[ADDR_W-1:IDX_LSB], {IDX_LSB{1'b0}}};
                    end
                end
            end
            WB: if (mem_ack) begin
                state_d    = REFILL;
                mem_we_d   = 1'b0;
                mem_addr_d = {lat_q, {IDX_LSB{1'b0}}};
            end
            REFILL: if (mem_ack) begin
                state_d     = IDLE;
                mem_req_d   = 1'b0;
                refill_done = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            vic_q       <= '0;
            lat_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            vic_q       <= vic_d;
            lat_q       <= lat_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // The store that missed is applied later, when the request replays as a hit.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++) begin
                    tag_q[w][s]   <= '0;
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                    data_q[w][s]  <= '0;
                end
        end else if (refill_done) begin
            tag_q[vic_q][lat_idx]   <= lat_tag;
            valid_q[vic_q][lat_idx] <= 1'b1;
            dirty_q[vic_q][lat_idx] <= 1'b0;
            data_q[vic_q][lat_idx]  <= mem_rdata;
        end else if (wr_hit) begin
            data_q[hit_way][idx][{word, 5'd0} +: 32] <= cpu_wdata;
            dirty_q[hit_way][idx]                    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_assoc_wb_cache.sv
// tb/tb_assoc_wb_cache.sv - self-checking bench for assoc_wb_cache with a line-memory responder
module tb_assoc_wb_cache;
    localparam int WAYS = 2;
    localparam int SETS = 64;

    logic         clk = 1'b0;
    logic         rst_b = 1'b0;
    logic         cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0]  cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
    logic         cpu_ready;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ack = 1'b0;

    always #5 clk = ~clk;

    assoc_wb_cache #(.WAYS(2), .SET_BITS(6), .WORD_BITS(2), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { bit we; logic [31:0] addr; logic [127:0] data; } tx_t;
    tx_t tx_q[$];
    int  req_cyc = 0;

    // Backing memory and the architectural view (what a load must return), keyed by word address.
    logic [31:0] mem_w [int unsigned];
    logic [31:0] ref_w [int unsigned];
    // Model of cache residency: line number -> last use time, plus dirty lines.
    longint      last_use [int unsigned];
    bit          dirty_m  [int unsigned];
    longint      tick = 0;

    typedef struct {
        bit we; logic [31:0] addr; logic [31:0] wd; int dly;
        int lat; int ntx; logic [31:0] rd; logic [31:0] wb_addr; logic [31:0] wb_w0;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] init_w(input int unsigned wa);
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] mem_rd(input int unsigned wa);
        return mem_w.exists(wa) ? mem_w[wa] : init_w(wa);
    endfunction

    function automatic logic [31:0] ref_rd(input int unsigned wa);
        return ref_w.exists(wa) ? ref_w[wa] : init_w(wa);
    endfunction

    // Called just after a rising edge; acks the dly-th cycle of each request.
    task automatic mem_side(input int dly);
        int unsigned base;
        mem_ack = 1'b0;
        if (mem_req) begin
            req_cyc++;
            if (req_cyc >= dly) begin
                mem_ack = 1'b1;
                req_cyc = 0;
                base = mem_addr >> 2;
                tx_q.push_back('{mem_we, mem_addr, mem_wdata});
                for (int i = 0; i < 4; i++) begin
                    if (mem_we) mem_w[base + i] = mem_wdata[32*i +: 32];
                    else        mem_rdata[32*i +: 32] = mem_rd(base + i);
                end
            end
        end
    endtask

    task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd, input int dly,
                          output logic [31:0] rd, output int lat);
        bit done = 0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        lat = 0; rd = '0; tx_q.delete();
        for (int c = 0; c < 200 && !done; c++) begin
            mem_side(dly);
            @(negedge clk);
            if (cpu_ready) begin
                rd = cpu_rdata;
                done = 1;
            end else begin
                lat++;
                @(posedge clk); #1;
            end
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL access_timeout: addr 0x%0h never completed, required completion within 200 cycles", a);
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        cpu_req = 1'b0;
    endtask

    task automatic mcheck(input bit we, input logic [31:0] a, input logic [31:0] wd, input int dly);
        int unsigned line, set, ev, n_in;
        longint oldest;
        bit hit, wb;
        logic [31:0] exp_rd, rd;
        logic [31:0] exp_wb [4];
        int lat, exp_lat, exp_ntx;
        line = a >> 4; set = line % SETS; exp_rd = ref_rd(a >> 2);
        hit = last_use.exists(line); wb = 0; ev = 0; n_in = 0; oldest = 0;
        for (int i = 0; i < 4; i++) exp_wb[i] = '0;
        if (!hit) begin
            foreach (last_use[l]) if (l % SETS == set) begin
                n_in++;
                if (n_in == 1 || last_use[l] < oldest) begin oldest = last_use[l]; ev = l; end
            end
            if (n_in == WAYS) begin
                wb = dirty_m.exists(ev);
                for (int i = 0; i < 4; i++) exp_wb[i] = ref_rd(ev * 4 + i);
                last_use.delete(ev);
                dirty_m.delete(ev);
            end
        end
        tick++;
        last_use[line] = tick;
        access(we, a, wd, dly, rd, lat);
        exp_lat = hit ? 0 : (wb ? 2 * dly + 1 : dly + 1);
        exp_ntx = hit ? 0 : (wb ? 2 : 1);
        chk($sformatf("latency a=%0h", a), 64'(lat), 64'(exp_lat));
        chk($sformatf("mem_txns a=%0h", a), 64'(tx_q.size()), 64'(exp_ntx));
        if (!we) chk($sformatf("rdata a=%0h", a), rd, exp_rd);
        if (tx_q.size() == exp_ntx && exp_ntx > 0) begin
            chk("refill_addr", tx_q[exp_ntx-1].addr, {a[31:4], 4'h0});
            chk("refill_we", 64'(tx_q[exp_ntx-1].we), 64'd0);
            if (wb) begin
                chk("wb_addr", tx_q[0].addr, ev << 4);
                for (int i = 0; i < 4; i++)
                    chk($sformatf("wb_word%0d", i), tx_q[0].data[32*i +: 32], exp_wb[i]);
            end
        end
        if (we) begin
            ref_w[a >> 2] = wd;
            dirty_m[line] = 1;
        end
    endtask

    task automatic model_reset();
        last_use.delete();
        dirty_m.delete();
        ref_w = mem_w;
        req_cyc = 0;
    endtask

    initial begin
        logic [31:0] rd, a;
        int lat;

        vecs[0]  = '{0, 32'h004, 32'h0,  3, 4, 1, 32'hB1,        32'h0,   32'h0};
        vecs[1]  = '{0, 32'h00C, 32'h0,  1, 0, 0, 32'hD3,        32'h0,   32'h0};
        vecs[2]  = '{1, 32'h008, 32'h55, 1, 0, 0, 32'h0,         32'h0,   32'h0};
        vecs[3]  = '{0, 32'h008, 32'h0,  1, 0, 0, 32'h55,        32'h0,   32'h0};
        vecs[4]  = '{0, 32'h400, 32'h0,  2, 3, 1, 32'h4000_0000, 32'h0,   32'h0};
        vecs[5]  = '{0, 32'h000, 32'h0,  1, 0, 0, 32'hA0,        32'h0,   32'h0};
        vecs[6]  = '{0, 32'h800, 32'h0,  2, 3, 1, 32'h8000_0000, 32'h0,   32'h0};
        vecs[7]  = '{1, 32'h400, 32'h11, 1, 3, 2, 32'h0,         32'h000, 32'hA0};
        vecs[8]  = '{0, 32'h000, 32'h0,  2, 3, 1, 32'hA0,        32'h0,   32'h0};
        vecs[9]  = '{0, 32'h800, 32'h0,  1, 3, 2, 32'h8000_0000, 32'h400, 32'h11};
        vecs[10] = '{0, 32'h008, 32'h0,  1, 0, 0, 32'h55,        32'h0,   32'h0};
        vecs[11] = '{0, 32'h400, 32'h0,  1, 2, 1, 32'h11,        32'h0,   32'h0};

        mem_w[0] = 32'hA0; mem_w[1] = 32'hB1; mem_w[2] = 32'hC2; mem_w[3] = 32'hD3;
        for (int i = 0; i < 4; i++) begin
            mem_w[32'h100 + i] = 32'h4000_0000 + i;
            mem_w[32'h200 + i] = 32'h8000_0000 + i;
        end

        cpu_req = 1'b1;
        #12;
        chk("rst_cpu_ready", 64'(cpu_ready), 64'd0);
        chk("rst_cpu_rdata", cpu_rdata, 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", 64'(|mem_wdata), 64'd0);
        cpu_req = 1'b0;
        @(posedge clk); #1 rst_b = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].dly, rd, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("vec%0d_txns", i), 64'(tx_q.size()), 64'(vecs[i].ntx));
            if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
            if (tx_q.size() == vecs[i].ntx && vecs[i].ntx > 0) begin
                chk($sformatf("vec%0d_refill_addr", i), tx_q[vecs[i].ntx-1].addr, {vecs[i].addr[31:4], 4'h0});
                chk($sformatf("vec%0d_refill_we", i), 64'(tx_q[vecs[i].ntx-1].we), 64'd0);
                if (vecs[i].ntx == 2) begin
                    chk($sformatf("vec%0d_wb_we", i), 64'(tx_q[0].we), 64'd1);
                    chk($sformatf("vec%0d_wb_addr", i), tx_q[0].addr, vecs[i].wb_addr);
                    chk($sformatf("vec%0d_wb_word0", i), tx_q[0].data[31:0], vecs[i].wb_w0);
                end
            end
        end

        // Dirty set 5, then assert reset while the write-back is pending.
        mcheck(1, 32'h050, 32'hCAFE_0001, 2);
        mcheck(1, 32'h450, 32'hCAFE_0002, 1);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h850;
        @(negedge clk);
        chk("wbrst_miss_ready", 64'(cpu_ready), 64'd0);
        @(posedge clk); #1;
        chk("wbrst_mem_req", 64'(mem_req), 64'd1);
        chk("wbrst_mem_we", 64'(mem_we), 64'd1);
        chk("wbrst_mem_addr", mem_addr, 64'h050);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("midrst_mem_req", 64'(mem_req), 64'd0);
        chk("midrst_mem_we", 64'(mem_we), 64'd0);
        chk("midrst_mem_addr", mem_addr, 64'd0);
        chk("midrst_mem_wdata", 64'(|mem_wdata), 64'd0);
        chk("midrst_cpu_ready", 64'(cpu_ready), 64'd0);
        chk("midrst_cpu_rdata", cpu_rdata, 64'd0);
        cpu_req = 1'b0;
        @(posedge clk); #1 rst_b = 1'b1;
        model_reset();
        @(posedge clk); #1;

        // Read 0x000 misses; ack on the first request cycle with cpu_req already dropped.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h000;
        @(negedge clk);
        chk("post_rst_ready", 64'(cpu_ready), 64'd0);
        @(posedge clk); #1;
        chk("post_rst_mem_req", 64'(mem_req), 64'd1);
        chk("post_rst_mem_we", 64'(mem_we), 64'd0);
        chk("post_rst_mem_addr", mem_addr, 64'h000);
        cpu_req = 1'b0;
        tx_q.delete();
        mem_side(1);
        tick++;
        last_use[0] = tick;
        @(posedge clk); #1 mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("dropped_req_idle%0d", i), {62'd0, mem_req, cpu_ready}, 64'd0);
            @(posedge clk); #1;
        end
        mcheck(0, 32'h00C, 32'h0, 1);

        for (int n = 0; n < 400; n++) begin
            a = ($urandom_range(0, 4) << 10) | ($urandom_range(0, 2) << 4) |
                ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) begin
                cpu_req = 1'b0; cpu_we = 1'($urandom_range(0, 1)); cpu_addr = a;
                @(negedge clk);
                chk("idle_no_activity", {62'd0, mem_req, cpu_ready}, 64'd0);
                @(posedge clk); #1;
            end else begin
                mcheck(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(1, 4)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
